paddsb_seq_ctrl: RTL and testbench

//  Sequencer that runs a packed saturating nibble add/sub (PADDSB-style) of width 4*NIBBLES
//  on one shared 4-bit saturating add/sub unit, one nibble per cycle, LSB nibble first.

---
 rtl/paddsb_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_paddsb_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/paddsb_seq_ctrl.sv
// Sequencer for a packed saturating nibble add/sub. Each request is processed one nibble
// per cycle, least significant lane first, on an external shared 4-bit saturating unit.
module paddsb_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic                 req_sub,
    output logic [3:0]           au_a,
    output logic [3:0]           au_b,
    output logic                 au_sub,
    input  logic [3:0]           au_sum,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [4*NIBBLES-1:0] resp_data,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic            sub_q,   sub_d;
    logic [W-1:0]    res_q,   res_d;

    logic [3:0]      lane_a;
    logic [3:0]      lane_b;

    // Lane select for the operand currently being sent to the shared unit.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                lane_a = a_q[4*i +: 4];
                lane_b = b_q[4*i +: 4];
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        res_d      = res_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        au_a       = 4'h0;
        au_b       = 4'h0;
        au_sub     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    sub_d   = req_sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                busy   = 1'b1;
                au_a   = lane_a;
                au_b   = lane_b;
                au_sub = sub_q;
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) begin
                        res_d[4*i +: 4] = au_sum;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            ST_DONE: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments only; all of them, results
    // included, clear on reset so an aborted operation leaves nothing visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
        end
    end

    assign resp_data = res_q;

endmodule

// File: tb/tb_paddsb_seq_ctrl.sv
// Directed bench for paddsb_seq_ctrl (NIBBLES=4); the shared 4-bit unit is modelled here
// as a golden signed saturating add/sub.
module tb_paddsb_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_sub;
    logic [3:0]   au_a;
    logic [3:0]   au_b;
    logic         au_sub;
    logic [3:0]   au_sum;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    paddsb_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .au_a       (au_a),
        .au_b       (au_b),
        .au_sub     (au_sub),
        .au_sum     (au_sum),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sat4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int sa, sb, r;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        r  = s ? sa - sb : sa + sb;
        if (r > 7)  return 4'h7;
        if (r < -8) return 4'h8;
        return 4'(r);
    endfunction

    assign au_sum = sat4(au_a, au_b, au_sub);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and collect the response; lat counts cycles from accept edge to
    // resp_valid (99 on timeout), seq holds the au_a lanes seen during RUN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] data, output int lat, output logic [W-1:0] seq);
        int t;
        seq = '0;
        lat = 99;
        data = 'x;
        t = 0;
        while (!req_ready && t < 20) begin
            tick();
            t++;
        end
        req_a = a; req_b = b; req_sub = s; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_a = ~a; req_b = ~b; req_sub = ~s;
        for (int k = 0; k < 20; k++) begin
            if (resp_valid) begin
                lat = k;
                break;
            end
            if (k < NIB) seq[4*k +: 4] = au_a;
            tick();
        end
        data = resp_data;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        n_checks++; if (resp_data !== 16'h0) begin n_fail++; $display("FAIL rst_resp_data got %h exp 0000", resp_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_checks++; if ({au_a, au_b, au_sub} !== 9'h0) begin n_fail++; $display("FAIL rst_au got %h/%h/%b exp 0/0/0", au_a, au_b, au_sub); end
    endtask

    task automatic test_add();
        logic [W-1:0] d, sq;
        int lat;
        run_op(16'h1234, 16'h1111, 1'b0, d, lat, sq);
        n_checks++; if (d !== 16'h2345) begin n_fail++; $display("FAIL add_data got %h exp 2345", d); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency got %0d exp 4", lat); end
        n_checks++; if (sq !== 16'h1234) begin n_fail++; $display("FAIL add_au_a_seq got %h exp 1234", sq); end
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL add_after_hs got rv=%b rr=%b exp 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_saturate();
        logic [W-1:0] d, sq;
        int lat;
        run_op(16'h7777, 16'h1111, 1'b0, d, lat, sq);
        n_checks++; if (d !== 16'h7777) begin n_fail++; $display("FAIL pos_sat got %h exp 7777", d); end
        run_op(16'h8888, 16'h1111, 1'b1, d, lat, sq);
        n_checks++; if (d !== 16'h8888) begin n_fail++; $display("FAIL neg_sat got %h exp 8888", d); end
        run_op(16'h3456, 16'h7777, 1'b1, d, lat, sq);
        n_checks++; if (d !== 16'hCDEF) begin n_fail++; $display("FAIL sub_neg got %h exp cdef", d); end
    endtask

    task automatic test_mixed_lanes();
        logic [W-1:0] d, sq;
        int lat;
        run_op(16'h7080, 16'h1F1F, 1'b0, d, lat, sq);
        n_checks++; if (d !== 16'h7F9F) begin n_fail++; $display("FAIL mixed_data got %h exp 7f9f", d); end
        // sq is packed lane-0-first, so lanes 0,8,0,7 read back as 7080.
        n_checks++; if (sq !== 16'h7080) begin n_fail++; $display("FAIL mixed_au_a_seq got %h exp 7080", sq); end
    endtask

    task automatic test_backpressure();
        int lat;
        req_a = 16'h4321; req_b = 16'h1111; req_sub = 1'b0; req_valid = 1'b1;
        tick();
        req_a = 16'h1111; req_b = 16'h2222; req_sub = 1'b0;
        for (int k = 0; k < NIB; k++) tick();
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", k, resp_valid); end
            n_checks++; if (resp_data !== 16'h5432) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp 5432", k, resp_data); end
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d] got %b exp 0", k, req_ready); end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_hs got rv=%b rr=%b exp 0/1", resp_valid, req_ready); end
        tick();
        req_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_reaccept got busy=%b rr=%b exp 1/0", busy, req_ready); end
        lat = 99;
        for (int k = 0; k < 20; k++) begin
            if (resp_valid) begin lat = k; break; end
            tick();
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency got %0d exp 4", lat); end
        n_checks++; if (resp_data !== 16'h3333) begin n_fail++; $display("FAIL bp_second_data got %h exp 3333", resp_data); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] d, sq;
        int lat;
        req_a = 16'h1234; req_b = 16'h0101; req_sub = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (au_a !== 4'h2 || au_sub !== 1'b1) begin n_fail++; $display("FAIL mid_idx2 got au_a=%h au_sub=%b exp 2/1", au_a, au_sub); end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        #3 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst[%0d] got rv=%b rr=%b exp 0/1", k, resp_valid, req_ready); end
            tick();
        end
        run_op(16'h0101, 16'h0202, 1'b0, d, lat, sq);
        n_checks++; if (d !== 16'h0303) begin n_fail++; $display("FAIL post_rst_op got %h exp 0303", d); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [3] = '{16'h1234, 16'h5555, 16'h7080};
        logic [W-1:0] tb [3] = '{16'h1111, 16'h3333, 16'h1F1F};
        logic         ts [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] te [3] = '{16'h2345, 16'h2222, 16'h7F9F};
        int acc, prev, t;
        prev = 0;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!req_ready && t < 20) begin tick(); t++; end
            req_a = ta[k]; req_b = tb[k]; req_sub = ts[k];
            acc = cyc;
            tick();
            if (k == 2) req_valid = 1'b0;
            // Accepts recur every NIB RUN cycles + one DONE cycle + one IDLE cycle.
            if (k > 0) begin
                n_checks++; if (acc - prev !== NIB + 2) begin n_fail++; $display("FAIL b2b_interval[%0d] got %0d exp %0d", k, acc - prev, NIB + 2); end
            end
            prev = acc;
            t = 0;
            while (!resp_valid && t < 20) begin tick(); t++; end
            n_checks++; if (resp_data !== te[k]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h exp %h", k, resp_data, te[k]); end
            tick();
        end
        resp_ready = 1'b0;
        n_checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got busy=%b rv=%b exp 0/0", busy, resp_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0; resp_ready = 1'b0;
        #12;
        test_reset();
        #3 rst_n = 1'b1;
        tick();
        test_add();
        test_saturate();
        test_mixed_lanes();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
